// File: rtl/cand_ctrl_pkg.sv
// Shared types for the CAND clock-gate controller: FSM state encoding and
// a small helper used to size the settle/idle down-counter.
package cand_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b10,
    ST_IDLE = 2'b11
  } cand_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cand_sen_ctrl.sv
// Drives CAND.SEN: wakes the gated clock on request, acknowledges once it has
// settled, and gates it off again after IDLE_CYCLES of inactivity.
module cand_sen_ctrl
  import cand_ctrl_pkg::*;
#(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       BUSY,
  input  logic       FORCE_ON,
  output logic       SEN,
  output logic       ACK,
  output logic [1:0] STATE
);

  localparam int CNT_W = $clog2(max_int(WAKE_CYCLES, IDLE_CYCLES) + 1);

  // Reload values; the WAKE load is only used when WAKE_CYCLES > 0.
  localparam int WAKE_LOAD_I = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;
  localparam int IDLE_LOAD_I = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_LOAD_I);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_LOAD_I);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  /*
   * Handshake: REQ, BUSY and FORCE_ON are level inputs, all equivalent for
   * keeping the clock alive. ACK is high only while the state register is ON
   * or IDLE, so the consumer may use the gated clock exactly while ACK=1.
   * A wake in progress cannot be aborted except by RST.
   */

  cand_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             act;
  logic             sen_q;

  assign act = REQ | BUSY | FORCE_ON;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_OFF;
      cnt   <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (act) begin
            if (WAKE_CYCLES > 0) begin
              state <= ST_WAKE;
              cnt   <= WAKE_LOAD;
            end else begin
              state <= ST_ON;
            end
          end
        end
        ST_WAKE: begin
          if (cnt == '0) begin
            state <= ST_ON;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_ON: begin
          if (!act) begin
            state <= ST_IDLE;
            cnt   <= IDLE_LOAD;
          end
        end
        ST_IDLE: begin
          // Activity wins over expiry, even when the count has reached zero.
          if (act) begin
            state <= ST_ON;
          end else if (cnt == '0) begin
            state <= ST_OFF;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= ST_OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

  // SEN only changes while CLK is low, so the CAND AND gate never sees a runt.
  always_ff @(negedge CLK) begin
    if (RST) begin
      sen_q <= 1'b0;
    end else begin
      sen_q <= (state != ST_OFF);
    end
  end

  assign SEN   = sen_q;
  assign ACK   = (state == ST_ON) || (state == ST_IDLE);
  assign STATE = state;

endmodule

// File: tb/tb_cand_sen_ctrl.sv
// Directed, table-driven bench for cand_sen_ctrl with WAKE_CYCLES=2 and
// IDLE_CYCLES=4, plus a long FORCE_ON hold sequence.
module tb_cand_sen_ctrl;
  import cand_ctrl_pkg::*;

  localparam int WAKE_N = 2;
  localparam int IDLE_N = 4;

  logic       clk;
  logic       rst;
  logic       req;
  logic       busy;
  logic       force_on;
  logic       sen;
  logic       ack;
  logic [1:0] state;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       rst;
    logic       req;
    logic       busy;
    logic       force_on;
    logic [1:0] exp_state;
    logic       exp_ack;
    logic       exp_sen;
  } vec_t;

  vec_t vecs[$];

  cand_sen_ctrl #(
    .WAKE_CYCLES(WAKE_N),
    .IDLE_CYCLES(IDLE_N)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ      (req),
    .BUSY     (busy),
    .FORCE_ON (force_on),
    .SEN      (sen),
    .ACK      (ack),
    .STATE    (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Any SEN edge while CLK is high would chop a gated clock pulse.
  always @(sen) begin
    if ($time > 0) begin
      tests_run++;
      if (clk !== 1'b0) begin
        tests_failed++;
        $display("FAIL sen_edge_clk_low: clk=%b at SEN change t=%0t, expected 0", clk, $time);
      end
    end
  end

  // Driver: inputs change at negedge+1; STATE/ACK checked at posedge+2,
  // SEN checked at the following negedge+1.
  task automatic drive(input logic r, input logic rq, input logic b, input logic f);
    rst      = r;
    req      = rq;
    busy     = b;
    force_on = f;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    drive(v.rst, v.req, v.busy, v.force_on);
    @(posedge clk);
    #2;
    check($sformatf("v%0d_state", idx), state, v.exp_state);
    check($sformatf("v%0d_ack", idx), {1'b0, ack}, {1'b0, v.exp_ack});
    @(negedge clk);
    #1;
    check($sformatf("v%0d_sen", idx), {1'b0, sen}, {1'b0, v.exp_sen});
  endtask

  task automatic add(input logic r, input logic rq, input logic b, input logic f,
                     input logic [1:0] s, input logic a, input logic e);
    vec_t v;
    v.rst = r; v.req = rq; v.busy = b; v.force_on = f;
    v.exp_state = s; v.exp_ack = a; v.exp_sen = e;
    vecs.push_back(v);
  endtask

  initial begin
    int off_cycles;
    logic reached_off;
    tests_run    = 0;
    tests_failed = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);

    // rst req busy force | state ack sen
    // Reset held 3 cycles with REQ high.
    add(1, 1, 0, 0, ST_OFF,  0, 0);
    add(1, 1, 0, 0, ST_OFF,  0, 0);
    add(1, 1, 0, 0, ST_OFF,  0, 0);
    // Wake: two WAKE cycles, then ON.
    add(0, 1, 0, 0, ST_WAKE, 0, 1);
    add(0, 1, 0, 0, ST_WAKE, 0, 1);
    add(0, 1, 0, 0, ST_ON,   1, 1);
    add(0, 0, 1, 0, ST_ON,   1, 1);
    // Idle gate-off: 4 IDLE cycles then OFF.
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_OFF,  0, 0);
    add(0, 0, 0, 0, ST_OFF,  0, 0);
    // FORCE_ON pulse starts a wake; dropping act cannot abort it.
    add(0, 0, 0, 1, ST_WAKE, 0, 1);
    add(0, 0, 0, 0, ST_WAKE, 0, 1);
    add(0, 0, 0, 0, ST_ON,   1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    // BUSY pulse exactly at expiry (CNT=0): back to ON, no ACK/SEN drop.
    add(0, 0, 1, 0, ST_ON,   1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 1, 0, 0, ST_ON,   1, 1);
    add(0, 1, 0, 0, ST_ON,   1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_OFF,  0, 0);
    // Reset mid-WAKE with CNT=1.
    add(0, 1, 0, 0, ST_WAKE, 0, 1);
    add(1, 1, 0, 0, ST_OFF,  0, 0);
    add(0, 1, 0, 0, ST_WAKE, 0, 1);
    add(0, 1, 0, 0, ST_WAKE, 0, 1);
    add(0, 0, 0, 0, ST_ON,   1, 1);
    // Reset mid-IDLE.
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(0, 0, 0, 0, ST_IDLE, 1, 1);
    add(1, 0, 0, 0, ST_OFF,  0, 0);
    add(0, 0, 0, 0, ST_OFF,  0, 0);

    @(negedge clk);
    #1;
    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // FORCE_ON held alone: wake, then 100 cycles locked in ON.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (WAKE_N + 1) @(posedge clk);
    #2;
    for (int i = 0; i < 100; i++) begin
      check($sformatf("force_hold%0d_state", i), state, ST_ON);
      check($sformatf("force_hold%0d_ack", i), {1'b0, ack}, 2'b01);
      @(posedge clk);
      #2;
    end

    // Drop FORCE_ON: OFF must be reached exactly IDLE_N+1 edges later
    // (one edge into IDLE, IDLE_N edges in IDLE).
    @(negedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    off_cycles  = 0;
    reached_off = 1'b0;
    for (int i = 0; i < 20 && !reached_off; i++) begin
      @(posedge clk);
      #2;
      off_cycles++;
      if (state == ST_OFF) reached_off = 1'b1;
    end
    check("force_release_off", {1'b0, reached_off}, 2'b01);
    check("force_release_cycles", off_cycles[1:0], 2'(IDLE_N + 1));
    tests_run++;
    if (off_cycles != IDLE_N + 1) begin
      tests_failed++;
      $display("FAIL force_release_count: got %0d cycles, expected %0d", off_cycles, IDLE_N + 1);
    end
    check("force_release_ack", {1'b0, ack}, 2'b00);
    @(negedge clk);
    #1;
    check("force_release_sen", {1'b0, sen}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
